// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with prioritised trap/replay/redirect loading,
// post-redirect bubbles, misalignment flagging and a PC history buffer for replay.
module pc_gen #(
  parameter int          XLEN          = 32,
  parameter logic [31:0] RESET_VEC     = 32'h0000_2000,
  parameter int          INC           = 4,
  parameter int          HIST_DEPTH    = 4,
  parameter int          BUBBLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_target,
  input  logic                          trap_valid,
  input  logic [XLEN-1:0]               trap_vector,
  input  logic                          replay_valid,
  input  logic [$clog2(HIST_DEPTH)-1:0] replay_idx,
  output logic [XLEN-1:0]               pc_out,
  output logic                          pc_valid,
  output logic [XLEN-1:0]               pc_plus_inc,
  output logic                          misalign_err
);
  localparam logic [XLEN-1:0] RV   = XLEN'(RESET_VEC);
  localparam logic [XLEN-1:0] MASK = XLEN'(INC - 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INC);
  localparam logic [2:0]      BC   = 3'(BUBBLE_CYCLES);
  typedef enum logic [1:0] {INIT, RUN, BUBBLE} state_t;
  state_t          r_state, w_state_nx;
  logic [XLEN-1:0] r_pc, w_pc_nx, w_raw, w_tgt;
  logic [XLEN-1:0] r_hist [HIST_DEPTH];
  logic [2:0]      r_cnt, w_cnt_nx;
  logic            r_mis, w_mis_nx, w_load, w_replay, w_push;
  always_comb begin
    w_load     = (r_state != INIT) & (trap_valid | replay_valid | redirect_valid);
    w_replay   = replay_valid & !trap_valid;
    w_raw      = trap_valid ? trap_vector : redirect_target;
    w_tgt      = w_replay ? r_hist[replay_idx] : w_raw & ~MASK;
    w_mis_nx   = w_load & !w_replay & (|(w_raw & MASK));
    w_push     = (r_state == RUN) & (w_load | !stall);
    w_pc_nx    = w_load ? w_tgt : w_push ? r_pc + STEP : r_pc;
    w_cnt_nx   = w_load ? BC : (r_state == BUBBLE) ? r_cnt - 3'd1 : r_cnt;
    w_state_nx = (r_state == INIT) ? RUN :
                 w_load ? ((BC != 3'd0) ? BUBBLE : RUN) :
                 (r_state == BUBBLE && r_cnt == 3'd1) ? RUN : r_state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_pc    <= RV;
      r_cnt   <= 3'd0;
      r_mis   <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= RV;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_cnt   <= w_cnt_nx;
      r_mis   <= w_mis_nx;
      if (w_push) begin
        r_hist[0] <= r_pc;
        for (int i = 1; i < HIST_DEPTH; i++) r_hist[i] <= r_hist[i-1];
      end
    end
  end
  assign pc_out       = r_pc;
  assign pc_valid     = (r_state == RUN);
  assign pc_plus_inc  = r_pc + STEP;
  assign misalign_err = r_mis;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen; expected valid PCs are queued by the
// stimulus and popped by per-instance monitors whenever pc_valid is high.
module tb_pc_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic        rn0 = 0, st0 = 0, rv0 = 0, tv0 = 0, pv0 = 0;
  logic [31:0] rt0 = 0, tvec0 = 0;
  logic [1:0]  pidx0 = 0;
  logic [31:0] pc0, pi0;
  logic        v0, m0;
  logic        rn1 = 0;
  logic [7:0]  pc1, pi1;
  logic        v1, m1;
  logic        rn2 = 0, rv2 = 0;
  logic [31:0] rt2 = 0;
  logic [31:0] pc2, pi2;
  logic        v2, m2;
  logic [31:0] q0[$];
  logic [7:0]  q1[$];
  logic [31:0] q2[$];
  pc_gen u0 (.clk(clk), .reset_n(rn0), .stall(st0), .redirect_valid(rv0), .redirect_target(rt0),
    .trap_valid(tv0), .trap_vector(tvec0), .replay_valid(pv0), .replay_idx(pidx0),
    .pc_out(pc0), .pc_valid(v0), .pc_plus_inc(pi0), .misalign_err(m0));
  pc_gen #(.XLEN(8), .RESET_VEC(32'h0000_00F8)) u1 (.clk(clk), .reset_n(rn1), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_target(8'h00), .trap_valid(1'b0), .trap_vector(8'h00),
    .replay_valid(1'b0), .replay_idx(2'd0), .pc_out(pc1), .pc_valid(v1), .pc_plus_inc(pi1),
    .misalign_err(m1));
  pc_gen #(.BUBBLE_CYCLES(3)) u2 (.clk(clk), .reset_n(rn2), .stall(1'b0), .redirect_valid(rv2),
    .redirect_target(rt2), .trap_valid(1'b0), .trap_vector(32'h0), .replay_valid(1'b0),
    .replay_idx(2'd0), .pc_out(pc2), .pc_valid(v2), .pc_plus_inc(pi2), .misalign_err(m2));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    logic [31:0] e;
    if (v0) begin
      if (q0.size() == 0) chk("u0 unexpected valid pc", pc0, 32'hFFFF_FFFF);
      else begin
        e = q0.pop_front();
        chk("u0 pc_out", pc0, e);
        chk("u0 pc_plus_inc", pi0, e + 32'd4);
      end
    end
  end
  always @(negedge clk) begin
    logic [7:0] e, ep;
    if (v1) begin
      if (q1.size() == 0) chk("u1 unexpected valid pc", {24'd0, pc1}, 32'hFFFF_FFFF);
      else begin
        e  = q1.pop_front();
        ep = e + 8'd4;
        chk("u1 pc_out", {24'd0, pc1}, {24'd0, e});
        chk("u1 pc_plus_inc", {24'd0, pi1}, {24'd0, ep});
      end
    end
  end
  always @(negedge clk) begin
    logic [31:0] e;
    if (v2) begin
      if (q2.size() == 0) chk("u2 unexpected valid pc", pc2, 32'hFFFF_FFFF);
      else begin
        e = q2.pop_front();
        chk("u2 pc_out", pc2, e);
        chk("u2 pc_plus_inc", pi2, e + 32'd4);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    tick();
    tick();
    chk("u0 reset pc", pc0, 32'h2000);
    chk("u0 reset valid", {31'd0, v0}, 32'd0);
    chk("u0 reset misalign", {31'd0, m0}, 32'd0);
    // sequential run, then stalled misaligned redirect
    q0.push_back(32'h2000); q0.push_back(32'h2004); q0.push_back(32'h2008);
    q0.push_back(32'h3000); q0.push_back(32'h3004);
    rn0 = 1;
    tick(); tick(); tick();
    st0 = 1; rv0 = 1; rt0 = 32'h3002;
    tick();
    chk("u0 redirect bubble valid", {31'd0, v0}, 32'd0);
    chk("u0 redirect misalign", {31'd0, m0}, 32'd1);
    chk("u0 redirect pc", pc0, 32'h3000);
    st0 = 0; rv0 = 0;
    tick();
    chk("u0 misalign pulse end", {31'd0, m0}, 32'd0);
    chk("u0 valid after bubble", {31'd0, v0}, 32'd1);
    tick();
    @(negedge clk); #1;
    rn0 = 0;
    #1;
    chk("u0 async reset pc", pc0, 32'h2000);
    chk("u0 async reset valid", {31'd0, v0}, 32'd0);
    // replay, trap priority, misaligned trap, stall
    foreach (q0[i]) chk("u0 queue drained", q0[i], 32'hFFFF_FFFF);
    q0 = {32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2010, 32'h2014, 32'h2008, 32'h2014,
          32'h100, 32'h104, 32'h2014, 32'h200, 32'h204, 32'h204, 32'h204, 32'h208};
    tick();
    rn0 = 1;
    repeat (6) tick();
    pv0 = 1; pidx0 = 2;
    tick();
    chk("u0 replay2 pc", pc0, 32'h2008);
    chk("u0 replay bubble valid", {31'd0, v0}, 32'd0);
    chk("u0 replay no misalign", {31'd0, m0}, 32'd0);
    pv0 = 0;
    tick();
    pv0 = 1; pidx0 = 0;
    tick();
    chk("u0 replay0 pc", pc0, 32'h2014);
    pv0 = 0;
    tick();
    tv0 = 1; tvec0 = 32'h100; pv0 = 1; pidx0 = 1; rv0 = 1; rt0 = 32'h3001;
    tick();
    chk("u0 trap priority pc", pc0, 32'h100);
    chk("u0 dropped redirect no misalign", {31'd0, m0}, 32'd0);
    tv0 = 0; pv0 = 0; rv0 = 0;
    tick(); tick();
    pv0 = 1; pidx0 = 1;
    tick();
    chk("u0 replay of trap push", pc0, 32'h2014);
    pv0 = 0;
    tick();
    tv0 = 1; tvec0 = 32'h203;
    tick();
    chk("u0 misaligned trap pc", pc0, 32'h200);
    chk("u0 misaligned trap flag", {31'd0, m0}, 32'd1);
    tv0 = 0;
    tick();
    chk("u0 trap misalign pulse end", {31'd0, m0}, 32'd0);
    tick();
    st0 = 1;
    tick(); tick();
    st0 = 0;
    tick();
    @(negedge clk); #1;
    rn0 = 0;
    // 8-bit wrap
    q1 = {8'hF8, 8'hFC, 8'h00, 8'h04};
    chk("u1 reset pc", {24'd0, pc1}, 32'hF8);
    rn1 = 1;
    repeat (4) tick();
    @(negedge clk); #1;
    rn1 = 0;
    // three-cycle bubbles, redirect inside a bubble, reset mid-bubble
    q2 = {32'h2000, 32'h2004, 32'h5000};
    rn2 = 1;
    tick(); tick();
    rv2 = 1; rt2 = 32'h4000;
    tick();
    chk("u2 bubble1 valid", {31'd0, v2}, 32'd0);
    rv2 = 0;
    tick();
    chk("u2 bubble2 valid", {31'd0, v2}, 32'd0);
    rv2 = 1; rt2 = 32'h5000;
    tick();
    chk("u2 second redirect pc", pc2, 32'h5000);
    rv2 = 0;
    n = 0;
    while (!v2 && n < 20) begin
      tick();
      n++;
    end
    chk("u2 invalid cycles after second redirect", n, 32'd3);
    rv2 = 1; rt2 = 32'h6000;
    tick();
    rv2 = 0;
    chk("u2 third redirect pc", pc2, 32'h6000);
    tick();
    rn2 = 0;
    #1;
    chk("u2 mid-bubble reset pc", pc2, 32'h2000);
    chk("u2 mid-bubble reset valid", {31'd0, v2}, 32'd0);
    repeat (3) tick();
    chk("u0 queue empty", q0.size(), 32'd0);
    chk("u1 queue empty", q1.size(), 32'd0);
    chk("u2 queue empty", q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
